// File: rtl/irq_gateway_pkg.sv
// Shared types for the interrupt gateway.
// Holds the per-source gateway state encoding.
package irq_gateway_pkg;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_CLAIMED
  } gw_state_t;

endpackage

// File: rtl/irq_gateway_cell.sv
// One interrupt source: synchroniser, rise detect, 1-deep edge latch, FSM.
// Ports: clk, reset, src, claim/complete hits; req/claimed/drop outputs.
module irq_gateway_cell
  import irq_gateway_pkg::*;
#(
  parameter bit EDGE        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter int ID          = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic req,
  output logic claimed,
  output logic drop
);

  if (ID < 1 || SYNC_STAGES < 1) begin : g_bad_cfg
    $error("irq_gateway_cell: bad ID or SYNC_STAGES");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  logic                   trig;
  logic                   latch_q;
  logic                   drop_q;
  gw_state_t              state_q;

  assign s = sync_q[SYNC_STAGES-1];

  // The chain is zeroed by reset, which is not a real sample of the
  // line; vld_q marks when s_prev holds a genuine post-reset value so
  // a line held high across reset does not look like a new edge.
  assign rise = EDGE & s & ~s_prev & vld_q[SYNC_STAGES];
  assign trig = EDGE ? (rise | latch_q) : s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      vld_q   <= '0;
      s_prev  <= 1'b0;
      latch_q <= 1'b0;
      drop_q  <= 1'b0;
      state_q <= GW_IDLE;
    end else begin
      sync_q[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      s_prev <= s;
      drop_q <= 1'b0;
      case (state_q)
        GW_IDLE: begin
          if (trig) begin
            state_q <= GW_PENDING;
            // a fresh rise arriving with the latch also set is
            // kept as the next event rather than silently merged
            latch_q <= rise & latch_q;
          end
        end
        GW_PENDING: begin
          if (rise) begin
            if (latch_q) drop_q <= 1'b1;
            else         latch_q <= 1'b1;
          end
          if (claim) state_q <= GW_CLAIMED;
        end
        GW_CLAIMED: begin
          if (rise) begin
            if (latch_q) drop_q <= 1'b1;
            else         latch_q <= 1'b1;
          end
          if (complete) state_q <= GW_IDLE;
        end
        default: state_q <= GW_IDLE;
      endcase
    end
  end

  assign req     = (state_q == GW_PENDING);
  assign claimed = (state_q == GW_CLAIMED);
  assign drop    = drop_q;

endmodule

// File: rtl/irq_gateway.sv
// Per-source interrupt gateways feeding the PLIC request vector.
// Ports: src_i raw lines, claim/complete strobes+IDs; req_o/claimed_o/drop_o.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int               IRQ_CNT     = 8,
  parameter logic [IRQ_CNT:1] EDGE_MASK   = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IRQ_CNT:1]         src_i,
  input  logic                     claim_i,
  input  logic [$clog2(IRQ_CNT):0] claim_id_i,
  input  logic                     complete_i,
  input  logic [$clog2(IRQ_CNT):0] complete_id_i,
  output logic [IRQ_CNT:1]         req_o,
  output logic [IRQ_CNT:1]         claimed_o,
  output logic [IRQ_CNT:1]         drop_o
);

  localparam int IDW = $clog2(IRQ_CNT) + 1;

  // ID 0 and IDs above IRQ_CNT never match any cell
  for (genvar i = 1; i <= IRQ_CNT; i++) begin : g_cell
    logic claim_hit;
    logic complete_hit;

    assign claim_hit    = claim_i    && (claim_id_i    == IDW'(i));
    assign complete_hit = complete_i && (complete_id_i == IDW'(i));

    irq_gateway_cell #(
      .EDGE        (EDGE_MASK[i]),
      .SYNC_STAGES (SYNC_STAGES),
      .ID          (i)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .src      (src_i[i]),
      .claim    (claim_hit),
      .complete (complete_hit),
      .req      (req_o[i]),
      .claimed  (claimed_o[i]),
      .drop     (drop_o[i])
    );
  end

endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway.
// Behavioural model + per-cycle compare + directed literal checks.
module tb_irq_gateway;

  localparam int             IRQ_CNT   = 8;
  localparam int             SYNC      = 2;
  localparam logic [IRQ_CNT:1] EMASK   = 8'b0111_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [IRQ_CNT:1]   src_i;
  logic               claim_i;
  logic [3:0]         claim_id_i;
  logic               complete_i;
  logic [3:0]         complete_id_i;
  logic [IRQ_CNT:1]   req_o;
  logic [IRQ_CNT:1]   claimed_o;
  logic [IRQ_CNT:1]   drop_o;

  int n_cmp = 0;
  int n_bad = 0;

  irq_gateway #(
    .IRQ_CNT     (IRQ_CNT),
    .EDGE_MASK   (EMASK),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_i         (src_i),
    .claim_i       (claim_i),
    .claim_id_i    (claim_id_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .req_o         (req_o),
    .claimed_o     (claimed_o),
    .drop_o        (drop_o)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  // st: 0 idle, 1 pending, 2 claimed
  int               m_st  [1:IRQ_CNT];
  bit               m_lat [1:IRQ_CNT];
  bit               m_drp [1:IRQ_CNT];
  logic [IRQ_CNT:1] hist [$];

  initial begin
    for (int i = 1; i <= IRQ_CNT; i++) begin
      m_st[i] = 0; m_lat[i] = 0; m_drp[i] = 0;
    end
  end

  always @(posedge clk) begin : model
    logic [IRQ_CNT:1] sv;
    logic [IRQ_CNT:1] pv;
    bit have_prev;
    bit rise;
    bit ev;
    if (reset) begin
      for (int i = 1; i <= IRQ_CNT; i++) begin
        m_st[i] = 0; m_lat[i] = 0; m_drp[i] = 0;
      end
      hist.delete();
    end else begin
      // s is the line as sampled SYNC edges ago since reset release
      sv = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
      have_prev = (hist.size() >= SYNC + 1);
      pv = have_prev ? hist[hist.size()-SYNC-1] : '0;
      for (int i = 1; i <= IRQ_CNT; i++) begin
        rise = EMASK[i] && have_prev && sv[i] && !pv[i];
        m_drp[i] = 0;
        if (m_st[i] == 0) begin
          ev = EMASK[i] ? (rise || m_lat[i]) : sv[i];
          if (ev) begin
            m_st[i] = 1;
            m_lat[i] = rise && m_lat[i];
          end
        end else begin
          if (rise && m_lat[i]) m_drp[i] = 1;
          if (rise) m_lat[i] = 1;
          if (m_st[i] == 1 && claim_i && claim_id_i == 4'(i))
            m_st[i] = 2;
          else if (m_st[i] == 2 && complete_i && complete_id_i == 4'(i))
            m_st[i] = 0;
        end
      end
      hist.push_back(src_i);
    end
  end

  always @(negedge clk) begin : compare
    logic [IRQ_CNT:1] er, ec, ed;
    for (int i = 1; i <= IRQ_CNT; i++) begin
      er[i] = (m_st[i] == 1);
      ec[i] = (m_st[i] == 2);
      ed[i] = m_drp[i];
    end
    n_cmp++;
    if (req_o !== er || claimed_o !== ec || drop_o !== ed) begin
      n_bad++;
      $display("FAIL model t=%0t req=%b/%b claimed=%b/%b drop=%b/%b (got/exp)",
               $time, req_o, er, claimed_o, ec, drop_o, ed);
    end
  end

  // ---------------- directed ----------------
  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic claim(input logic [3:0] id);
    claim_i = 1'b1; claim_id_i = id;
    cyc(1);
    claim_i = 1'b0;
  endtask

  task automatic complete(input logic [3:0] id);
    complete_i = 1'b1; complete_id_i = id;
    cyc(1);
    complete_i = 1'b0;
  endtask

  task automatic pulse(input int i);
    src_i[i] = 1'b1;
    cyc(2);
    src_i[i] = 1'b0;
    cyc(3);
  endtask

  int drops;

  initial begin
    reset = 1'b1; src_i = '0;
    claim_i = 0; claim_id_i = 0; complete_i = 0; complete_id_i = 0;
    cyc(2);
    chk("rst_out", {req_o | claimed_o | drop_o}, 8'h00);

    // level source 3 from reset release
    reset = 1'b0; src_i[3] = 1'b1;
    cyc(2);
    chk("lvl_c2", req_o, 8'h00);
    cyc(1);
    chk("lvl_c3", req_o, 8'h04);
    chk("lvl_c3_clm", claimed_o, 8'h00);
    claim(3);
    chk("lvl_clm_req", req_o, 8'h00);
    chk("lvl_clm", claimed_o, 8'h04);
    complete(3);
    chk("lvl_cpl", {req_o | claimed_o}, 8'h00);
    cyc(1);
    chk("lvl_repend", req_o, 8'h04);
    src_i[3] = 1'b0;
    cyc(3);
    chk("lvl_hold", req_o, 8'h04);
    claim(3); complete(3); cyc(3);
    chk("lvl_idle", {req_o | claimed_o}, 8'h00);

    // edge source 5
    pulse(5);
    chk("edge_req", req_o, 8'h10);
    claim(5);
    pulse(5);
    chk("edge_clm", claimed_o, 8'h10);
    complete(5);
    chk("edge_cpl", {req_o | claimed_o}, 8'h00);
    cyc(1);
    chk("edge_replay", req_o, 8'h10);
    claim(5); complete(5); cyc(4);
    chk("edge_once", {req_o | claimed_o}, 8'h00);

    // third edge while latch full
    pulse(5); claim(5); pulse(5);
    drops = 0;
    src_i[5] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (k == 1) src_i[5] = 1'b0;
      drops += int'(drop_o[5]);
    end
    chk("drop_once", 8'(drops), 8'h01);
    complete(5); cyc(1); claim(5); complete(5); cyc(3);

    // simultaneous claim 6 / complete 2
    src_i[2] = 1'b1; cyc(3);
    claim(2);
    src_i[2] = 1'b0;
    pulse(6);
    chk("dual_pre_req", req_o, 8'h20);
    chk("dual_pre_clm", claimed_o, 8'h02);
    claim_i = 1; claim_id_i = 6; complete_i = 1; complete_id_i = 2;
    cyc(1);
    claim_i = 0; complete_i = 0;
    chk("dual_req", req_o, 8'h00);
    chk("dual_clm", claimed_o, 8'h20);
    complete(6); cyc(1);

    // ignored strobes
    src_i[4] = 1'b1; cyc(3);
    chk("ign_pre", req_o, 8'h08);
    claim(4'd0); claim(4'd9); claim(4'd1); complete(4'd4);
    chk("ign_req", req_o, 8'h08);
    chk("ign_clm", claimed_o, 8'h00);

    // reset with pending, claimed and latched state
    src_i[3] = 1'b1; cyc(3);
    claim(3);
    pulse(7);
    src_i[7] = 1'b1; cyc(3);
    chk("rst_pre_req", req_o, 8'h48);
    reset = 1'b1; cyc(1);
    chk("rst_mid", {req_o | claimed_o | drop_o}, 8'h00);
    cyc(1); reset = 1'b0;
    cyc(6);
    chk("rst_post_req", req_o, 8'h0C);
    chk("rst_post_clm", claimed_o, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
